// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Optional macro VGA_TIMING_CLKDIV_EN enables a CLK_DIV pixel-tick prescaler.
module vga_timing_gen #(
    parameter int POS_W       = 16,
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit H_SYNC_POL  = 1'b0,
    parameter bit V_SYNC_POL  = 1'b0,
    parameter int FRAME_CNT_W = 8,
    parameter int CLK_DIV     = 2
) (
    input  logic                   clkIn,
    input  logic                   rstIn,
    input  logic                   enIn,
    output logic [POS_W-1:0]       hPosOut,
    output logic [POS_W-1:0]       vPosOut,
    output logic                   isDisplayOnOut,
    output logic                   isHSyncOut,
    output logic                   isVSyncOut,
    output logic                   lineStartOut,
    output logic                   frameStartOut,
    output logic [FRAME_CNT_W-1:0] frameCntOut
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [POS_W-1:0] H_LAST = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] V_LAST = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0] H_VIS  = POS_W'(H_VISIBLE);
    localparam logic [POS_W-1:0] V_VIS  = POS_W'(V_VISIBLE);
    localparam logic [POS_W-1:0] HS_LO  = POS_W'(HS_START);
    localparam logic [POS_W-1:0] HS_HI  = POS_W'(HS_END);
    localparam logic [POS_W-1:0] VS_LO  = POS_W'(VS_START);
    localparam logic [POS_W-1:0] VS_HI  = POS_W'(VS_END);
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
    localparam logic [FRAME_CNT_W-1:0] FC_ONE = FRAME_CNT_W'(1);

    // Back porches of at least one keep the reset position outside sync.
    if (CLK_DIV < 1 || H_BACK < 1 || V_BACK < 1) begin : g_bad_param
        $error("vga_timing_gen: CLK_DIV, H_BACK and V_BACK must be >= 1");
    end

    logic tick;

`ifdef VGA_TIMING_CLKDIV_EN
    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

    logic [PRE_W-1:0] pre_q, pre_d;

    // Prescaler advances only while enabled; wraps on the tick clock.
    always_comb begin
        pre_d = pre_q;
        if (enIn) begin
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_ONE;
        end
    end

    assign tick = enIn && (pre_q == PRE_LAST);

    // Prescaler register.
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign tick = enIn;
`endif

    logic [POS_W-1:0]       h_q, h_d;
    logic [POS_W-1:0]       v_q, v_d;
    logic [FRAME_CNT_W-1:0] fc_q, fc_d;
    logic                   de_q, de_d;
    logic                   hs_q, hs_d;
    logic                   vs_q, vs_d;
    logic                   ls_q, ls_d;
    logic                   fs_q, fs_d;

    // Advance the raster and decode the levels from the new position.
    always_comb begin
        h_d  = h_q;
        v_d  = v_q;
        fc_d = fc_q;
        de_d = de_q;
        hs_d = hs_q;
        vs_d = vs_q;
        ls_d = 1'b0;
        fs_d = 1'b0;
        if (tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d  = '0;
                    fc_d = fc_q + FC_ONE;
                end else begin
                    v_d = v_q + POS_ONE;
                end
            end else begin
                h_d = h_q + POS_ONE;
            end
            de_d = (h_d < H_VIS) && (v_d < V_VIS);
            hs_d = ((h_d >= HS_LO) && (h_d < HS_HI)) ? H_SYNC_POL : ~H_SYNC_POL;
            vs_d = ((v_d >= VS_LO) && (v_d < VS_HI)) ? V_SYNC_POL : ~V_SYNC_POL;
            ls_d = (h_d == '0);
            fs_d = (h_d == '0) && (v_d == '0);
        end
    end

    // Raster state; reset parks on the last pixel so the first tick is (0,0).
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            h_q  <= H_LAST;
            v_q  <= V_LAST;
            fc_q <= '1;
            de_q <= 1'b0;
            hs_q <= ~H_SYNC_POL;
            vs_q <= ~V_SYNC_POL;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            fc_q <= fc_d;
            de_q <= de_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
        end
    end

    assign hPosOut        = h_q;
    assign vPosOut        = v_q;
    assign frameCntOut    = fc_q;
    assign isDisplayOnOut = de_q;
    assign isHSyncOut     = hs_q;
    assign isVSyncOut     = vs_q;
    assign lineStartOut   = ls_q;
    assign frameStartOut  = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen on a small raster.
// Two instances share stimulus: active-low and active-high sync polarity.
module tb_vga_timing_gen;

    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 4, VF = 1, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int TOT = HT * VT;
    localparam int CDIV = 2;
    localparam int PW = 16;
    localparam int FW = 2;

    logic clk = 1'b0;
    logic rstIn = 1'b1;
    logic enIn = 1'b0;

    logic [PW-1:0] hPos, vPos, hPosP, vPosP;
    logic de, hs, vs, ls, fs;
    logic deP, hsP, vsP, lsP, fsP;
    logic [FW-1:0] fc, fcP;

    vga_timing_gen #(
        .POS_W(PW), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .FRAME_CNT_W(FW), .CLK_DIV(CDIV)
    ) dut (
        .clkIn(clk), .rstIn(rstIn), .enIn(enIn),
        .hPosOut(hPos), .vPosOut(vPos), .isDisplayOnOut(de),
        .isHSyncOut(hs), .isVSyncOut(vs), .lineStartOut(ls),
        .frameStartOut(fs), .frameCntOut(fc)
    );

    vga_timing_gen #(
        .POS_W(PW), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .FRAME_CNT_W(FW), .CLK_DIV(CDIV)
    ) dut_p (
        .clkIn(clk), .rstIn(rstIn), .enIn(enIn),
        .hPosOut(hPosP), .vPosOut(vPosP), .isDisplayOnOut(deP),
        .isHSyncOut(hsP), .isVSyncOut(vsP), .lineStartOut(lsP),
        .frameStartOut(fsP), .frameCntOut(fcP)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h;
        int v;
        bit de;
        bit hs;
        bit vs;
        bit ls;
        bit fs;
        int fc;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_err = 0;
    int n_t = 0;
    int pre = 0;
    bit tk;

    // Expected outputs after n ticks since reset (active-low syncs).
    function automatic exp_t model(int n, bit t);
        exp_t e;
        int idx;
        if (n == 0) begin
            idx = TOT - 1;
            e.fc = (1 << FW) - 1;
        end else begin
            idx = (n - 1) % TOT;
            e.fc = ((n - 1) / TOT) % (1 << FW);
        end
        e.h = idx % HT;
        e.v = idx / HT;
        e.de = (e.h < HV) && (e.v < VV);
        e.hs = !((e.h >= HV + HF) && (e.h < HV + HF + HS));
        e.vs = !((e.v >= VV + VF) && (e.v < VV + VF + VS));
        e.ls = t && (e.h == 0);
        e.fs = t && (idx == 0);
        return e;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Drive one cycle of inputs and queue the response for the next edge.
    task automatic step(input bit en, input bit rst);
        @(negedge clk);
        enIn = en;
        rstIn = rst;
        if (!rst) begin
            n_t = 0;
            pre = 0;
            tk = 1'b0;
        end else begin
`ifdef VGA_TIMING_CLKDIV_EN
            tk = en && (pre == CDIV - 1);
            if (en) pre = (pre == CDIV - 1) ? 0 : pre + 1;
`else
            tk = en;
`endif
            if (tk) n_t++;
        end
        q.push_back(model(n_t, tk));
    endtask

    function automatic bit at(int h, int v);
        exp_t e;
        e = model(n_t, 1'b0);
        return (n_t > 0) && (e.h == h) && (e.v == v);
    endfunction

    // Monitor: pop one expectation per clock and compare both instances.
    initial begin : mon
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (int'(hPos) != e.h || int'(vPos) != e.v || de != e.de ||
                    hs != e.hs || vs != e.vs || ls != e.ls || fs != e.fs ||
                    int'(fc) != e.fc || hsP != !e.hs || vsP != !e.vs ||
                    int'(hPosP) != e.h || int'(vPosP) != e.v ||
                    lsP != e.ls || fsP != e.fs || int'(fcP) != e.fc) begin
                    n_err++;
                    $display("FAIL scoreboard @%0t: got h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d hsP=%b vsP=%b want h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d hsP=%b vsP=%b",
                             $time, hPos, vPos, de, hs, vs, ls, fs, fc, hsP, vsP,
                             e.h, e.v, e.de, e.hs, e.vs, e.ls, e.fs, e.fc,
                             !e.hs, !e.vs);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        enIn = 1'b1;
        #1 rstIn = 1'b0;
        #1;
        chk("rst_h", int'(hPos), HT - 1);
        chk("rst_v", int'(vPos), VT - 1);
        chk("rst_fc", int'(fc), (1 << FW) - 1);
        chk("rst_de", int'(de), 0);
        chk("rst_hs", int'(hs), 1);
        chk("rst_vs", int'(vs), 1);
        chk("rst_hsP", int'(hsP), 0);
        chk("rst_vsP", int'(vsP), 0);
        repeat (3) step(1'b1, 1'b0);

        for (int i = 0; i < 400 && !at(5, 2); i++) step(1'b1, 1'b1);
        repeat (37) step(1'b0, 1'b1);
        @(posedge clk);
        #2;
        chk("hold_h", int'(hPos), 5);
        chk("hold_v", int'(vPos), 2);
        chk("hold_ls", int'(ls), 0);
        chk("hold_fs", int'(fs), 0);

        repeat (5 * TOT * CDIV + 20) step(1'b1, 1'b1);
        for (int i = 0; i < 60; i++) step((i % 3) != 0, 1'b1);

        for (int i = 0; i < 400 && !at(7, 3); i++) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        #1;
        chk("arst_h", int'(hPos), HT - 1);
        chk("arst_v", int'(vPos), VT - 1);
        chk("arst_fc", int'(fc), (1 << FW) - 1);
        chk("arst_de", int'(de), 0);
        chk("arst_hs", int'(hs), 1);
        chk("arst_vs", int'(vs), 1);
        chk("arst_hsP", int'(hsP), 0);
        step(1'b1, 1'b0);
        repeat (40) step(1'b1, 1'b1);

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
